// File: rtl/bcd_pkg.sv
// Shared types, constants and elaboration-time helpers for the BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Digit code the downstream decoders show as all outputs inactive.
   localparam logic [3:0] BCD_BLANK = 4'hF;

   // 10**n, used to size the overflow threshold at elaboration time.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   // Smallest r with 2**r >= v.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
import bcd_pkg::*;

module bin_to_bcd_seq_adj_unused_guard;
endmodule

module bcd_digit_adj (
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);

   assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with valid/ready on both sides and one conversion in flight.
import bcd_pkg::*;

module bin_to_bcd_seq #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_ovf
);

   localparam int CNT_W = clog2(BIN_W + 1);
   // Comparison is done at least 64 bits wide so 10**DIGITS never truncates.
   localparam int CMP_W = (BIN_W > 64) ? BIN_W : 64;
   localparam logic [CMP_W-1:0] OVF_LIM = CMP_W'(pow10(DIGITS));

   state_t                      r_state;
   logic [BIN_W-1:0]            r_bin;
   logic [4*DIGITS-1:0]         r_bcd;
   logic [CNT_W-1:0]            r_cnt;
   logic                        r_ovf;
   logic                        r_out_valid;
   logic [4*DIGITS-1:0]         r_out_bcd;
   logic                        r_out_ovf;

   logic [4*DIGITS-1:0]         w_adj;
   logic [4*DIGITS+BIN_W-1:0]   w_cat;
   logic                        w_ovf;

   // Per-digit +3 correction ahead of the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_d (r_bcd[4*g +: 4]),
         .o_d (w_adj[4*g +: 4])
      );
   end

   // Corrected BCD and remaining binary bits shift left together; the bit
   // leaving the top digit is dropped, the overflow flag covers that case.
   assign w_cat = {w_adj, r_bin} << 1;
   assign w_ovf = (CMP_W'(in_bin) >= OVF_LIM);

   assign in_ready  = (r_state == IDLE) && !Reset;
   assign out_valid = r_out_valid;
   assign out_bcd   = r_out_bcd;
   assign out_ovf   = r_out_ovf;

   // Control FSM, iteration counter, shift registers and result registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_bcd   <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_bin   <= in_bin;
                  r_bcd   <= '0;
                  r_cnt   <= CNT_W'(BIN_W);
                  r_ovf   <= w_ovf;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_bcd <= w_cat[4*DIGITS+BIN_W-1:BIN_W];
               r_bin <= w_cat[BIN_W-1:0];
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
                  r_out_bcd   <= r_ovf ? {DIGITS{BCD_BLANK}}
                                       : w_cat[4*DIGITS+BIN_W-1:BIN_W];
                  r_out_ovf   <= r_ovf;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: a 4-digit and a 3-digit converter side by side.
module tb_bin_to_bcd_seq;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
   logic [9:0]  in_bin;
   logic [15:0] out_bcd;
   logic        in_valid3, in_ready3, out_valid3, out_ready3, out_ovf3;
   logic [9:0]  in_bin3;
   logic [11:0] out_bcd3;

   logic [16:0] q4[$];
   logic [16:0] q3[$];
   int n_chk = 0, n_fail = 0, n_rx4 = 0, n_rx3 = 0;

   always #5 Clk = ~Clk;

   bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) u_dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
      .out_bcd(out_bcd), .out_ovf(out_ovf));

   bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) u_dut3 (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_bin(in_bin3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_bcd(out_bcd3), .out_ovf(out_ovf3));

   // Decimal reference: {ovf, digits}, all digits 4'hF on overflow.
   function automatic logic [16:0] model(input int v, input int d);
      logic [15:0] b;
      logic        ovf;
      b   = '0;
      ovf = (v >= 10**d);
      for (int i = 0; i < d; i++)
         b[4*i +: 4] = ovf ? 4'hF : 4'((v / 10**i) % 10);
      return {ovf, b};
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Results are compared at the cycle the consumer takes them.
   always @(negedge Clk) begin
      if (!Reset && out_valid && out_ready) begin
         chk("q4 nonempty", 64'(q4.size() > 0), 1);
         if (q4.size() > 0) chk("dut4 result", {out_ovf, out_bcd}, q4.pop_front());
         n_rx4++;
      end
      if (!Reset && out_valid3 && out_ready3) begin
         chk("q3 nonempty", 64'(q3.size() > 0), 1);
         if (q3.size() > 0) chk("dut3 result", {out_ovf3, 4'h0, out_bcd3}, q3.pop_front());
         n_rx3++;
      end
   end

   // Presents v and returns #1 after the accepting edge; in_valid is left high.
   task automatic send(input int v, input bit push);
      int n = 0;
      while (!in_ready && n < 100) begin @(posedge Clk); #1; n++; end
      chk("send ready", in_ready, 1);
      in_valid = 1'b1;
      in_bin   = 10'(v);
      if (push) q4.push_back(model(v, 4));
      @(posedge Clk); #1;
   endtask

   task automatic send3(input int v);
      int n = 0;
      while (!in_ready3 && n < 100) begin @(posedge Clk); #1; n++; end
      chk("send3 ready", in_ready3, 1);
      in_valid3 = 1'b1;
      in_bin3   = 10'(v);
      q3.push_back(model(v, 3));
      @(posedge Clk); #1;
      in_valid3 = 1'b0;
   endtask

   task automatic lat(input int v);
      send(v, 1);
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge Clk); #1;
         if (k == 9)  chk("latency pre", out_valid, 0);
         if (k == 10) chk("latency rise", out_valid, 1);
      end
   endtask

   task automatic wait_rx(input int n);
      int c = 0;
      while (n_rx4 < n && c < 200) begin @(posedge Clk); #1; c++; end
      chk("rx count", n_rx4, n);
   endtask

   initial begin
      Reset = 1'b1; in_valid = 0; in_bin = 0; out_ready = 0;
      in_valid3 = 0; in_bin3 = 0; out_ready3 = 1;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst out_bcd", out_bcd, 0);
      chk("rst out_ovf", out_ovf, 0);
      chk("rst in_ready3", in_ready3, 0);
      Reset = 1'b0;
      @(posedge Clk); #1;
      chk("post rst in_ready", in_ready, 1);

      // basic conversions and latency
      out_ready = 1'b1;
      lat(255);
      wait_rx(1);
      lat(0);
      send(1023, 1);
      in_valid = 1'b0;
      wait_rx(3);

      // 3-digit instance: overflow boundary
      send3(1000);
      send3(999);
      begin
         int c = 0;
         while (n_rx3 < 2 && c < 200) begin @(posedge Clk); #1; c++; end
         chk("rx3 count", n_rx3, 2);
      end

      // backpressure
      out_ready = 1'b0;
      send(123, 1);
      in_valid = 1'b0;
      begin
         int c = 0;
         while (!out_valid && c < 40) begin @(posedge Clk); #1; c++; end
      end
      chk("bp valid", out_valid, 1);
      for (int k = 0; k < 6; k++) begin
         @(posedge Clk); #1;
         chk("bp bcd stable", out_bcd, 16'h0123);
         chk("bp in_ready", in_ready, 0);
         chk("bp out_valid", out_valid, 1);
         if (k == 2) begin in_valid = 1'b1; in_bin = 10'd5; end
         else in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge Clk); #1;
      chk("bp release valid", out_valid, 0);
      chk("bp release ready", in_ready, 1);
      wait_rx(4);
      repeat (12) @(posedge Clk);
      #1;
      chk("bp pulse ignored", out_valid, 0);

      // back-to-back with in_valid held
      send(37, 1);
      send(512, 1);
      in_valid = 1'b0;
      wait_rx(6);

      // reset mid-conversion
      send(200, 0);
      in_valid = 1'b0;
      repeat (4) @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst out_bcd", out_bcd, 0);
      chk("midrst out_ovf", out_ovf, 0);
      chk("midrst in_ready", in_ready, 0);
      @(posedge Clk); #1 Reset = 1'b0;
      @(posedge Clk); #1;
      chk("after rst in_ready", in_ready, 1);
      send(86, 1);
      in_valid = 1'b0;
      wait_rx(7);

      chk("q4 drained", q4.size(), 0);
      chk("q3 drained", q3.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
